// File: rtl/tmds_decoder.sv
// TMDS receive decoder: word alignment by control-token run detection,
// 10b-to-8b data decode, and control token extraction.
module tmds_decoder #(
  parameter int unsigned CTRL_LOCK      = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOSS_TIMEOUT   = 8192
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic [3:0] offset_out
);

  localparam int unsigned RUN_W   = $clog2(CTRL_LOCK + 1);
  localparam int unsigned DWELL_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned GAP_W   = $clog2(LOSS_TIMEOUT + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         offset_q, offset_d;
  logic [9:0]         prev_word_q, prev_word_d;
  logic [9:0]         aligned_q, aligned_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [1:0]         holdoff_q, holdoff_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         control_q, control_d;
  logic               ve_q, ve_d;
  logic               locked_q, locked_d;

  logic [19:0] window_c;
  logic        is_ctrl_c;
  logic [1:0]  ctrl_bits_c;
  logic [3:0]  next_offset_c;

  // Undo the transition-minimising XOR/XNOR chain and optional inversion
  function automatic logic [7:0] decode_word(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] b;
    d    = q[9] ? ~q[7:0] : q[7:0];
    b    = '0;
    b[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      b[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return b;
  endfunction

  always_comb begin
    is_ctrl_c   = 1'b1;
    ctrl_bits_c = 2'b00;
    case (aligned_q)
      10'b1101010100: ctrl_bits_c = 2'b00;
      10'b0010101011: ctrl_bits_c = 2'b01;
      10'b0101010100: ctrl_bits_c = 2'b10;
      10'b1010101011: ctrl_bits_c = 2'b11;
      default:        is_ctrl_c   = 1'b0;
    endcase
  end

  assign window_c      = {tmds_in, prev_word_q};
  assign next_offset_c = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  // Alignment FSM, counters and output decode
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    run_cnt_d   = run_cnt_q;
    dwell_d     = dwell_q;
    gap_d       = gap_q;
    holdoff_d   = holdoff_q;
    prev_word_d = tmds_in;
    aligned_d   = 10'(window_c >> offset_q);
    data_d      = 8'd0;
    control_d   = control_q;
    ve_d        = 1'b0;

    // Words straddling an offset change are discarded from the run count
    if (holdoff_q != 2'd0) begin
      holdoff_d = holdoff_q - 2'd1;
      run_cnt_d = '0;
    end else if (is_ctrl_c) begin
      if (run_cnt_q != RUN_W'(CTRL_LOCK)) run_cnt_d = run_cnt_q + RUN_W'(1);
    end else begin
      run_cnt_d = '0;
    end

    case (state_q)
      SEARCH: begin
        if (run_cnt_q == RUN_W'(CTRL_LOCK)) begin
          state_d = LOCKED;
          dwell_d = '0;
          gap_d   = '0;
        end else if (dwell_q == DWELL_W'(SEARCH_TIMEOUT - 1)) begin
          offset_d  = next_offset_c;
          dwell_d   = '0;
          run_cnt_d = '0;
          holdoff_d = 2'd2;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      LOCKED: begin
        if (is_ctrl_c) begin
          gap_d = '0;
        end else if (gap_q == GAP_W'(LOSS_TIMEOUT - 1)) begin
          state_d   = SEARCH;
          offset_d  = next_offset_c;
          run_cnt_d = '0;
          dwell_d   = '0;
          gap_d     = '0;
          holdoff_d = 2'd2;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = SEARCH;
    endcase

    if (state_q == LOCKED) begin
      if (is_ctrl_c) begin
        control_d = ctrl_bits_c;
      end else begin
        ve_d   = 1'b1;
        data_d = decode_word(aligned_q);
      end
    end else begin
      control_d = 2'b00;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= SEARCH;
      offset_q    <= 4'd0;
      prev_word_q <= 10'd0;
      aligned_q   <= 10'd0;
      run_cnt_q   <= '0;
      dwell_q     <= '0;
      gap_q       <= '0;
      holdoff_q   <= 2'd0;
      data_q      <= 8'd0;
      control_q   <= 2'd0;
      ve_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      prev_word_q <= prev_word_d;
      aligned_q   <= aligned_d;
      run_cnt_q   <= run_cnt_d;
      dwell_q     <= dwell_d;
      gap_q       <= gap_d;
      holdoff_q   <= holdoff_d;
      data_q      <= data_d;
      control_q   <= control_d;
      ve_q        <= ve_d;
      locked_q    <= locked_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = control_q;
  assign ve_out      = ve_q;
  assign locked_out  = locked_q;
  assign offset_out  = offset_q;

endmodule
